// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator/checker pair: FSM states and the
// standard polynomial constants (width plus Fibonacci tap mask).
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } prbs_state_e;

  // Tap masks select state bits whose XOR is the next bit (bit n-1 = x^n term).
  localparam int          PRBS7_W     = 7;
  localparam logic [31:0] PRBS7_TAPS  = 32'h0000_0060;
  localparam int          PRBS15_W    = 15;
  localparam logic [31:0] PRBS15_TAPS = 32'h0000_6000;
  localparam int          PRBS23_W    = 23;
  localparam logic [31:0] PRBS23_TAPS = 32'h0042_0000;
  localparam int          PRBS31_W    = 31;
  localparam logic [31:0] PRBS31_TAPS = 32'h4800_0000;

  // Counter width able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Local Fibonacci LFSR for the checker: shifts either the received bit
// (acquisition) or its own prediction (free-run) into the LSB.
module prbs_lfsr_core #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = 7'h60
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_shift,
  input  logic i_sel_pred,
  input  logic i_bit,
  output logic o_pred,
  output logic o_zero
);

  logic [WIDTH-1:0] r_state;
  logic             w_pred;
  logic             w_shift_bit;

  assign w_pred      = ^(r_state & TAPS);
  assign w_shift_bit = i_sel_pred ? w_pred : i_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
    end else if (i_shift) begin
      r_state <= {r_state[WIDTH-2:0], w_shift_bit};
    end
  end

  assign o_pred = w_pred;
  assign o_zero = (r_state == '0);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker with lock detection and saturating
// error count. Optional loss-of-lock relock: define PRBS_CHK_AUTO_RELOCK_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH      = 7,
  parameter logic [WIDTH-1:0] TAPS       = 7'h60,
  parameter int               LOCK_CNT   = 16,
  parameter int               ERR_CNT_W  = 16,
  parameter int               WINDOW     = 64,
  parameter int               UNLOCK_ERR = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sat,
  output prbs_state_e          dbg_state
);

  localparam int FILL_W  = cnt_width(WIDTH);
  localparam int MATCH_W = 8;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prbs_checker: WIDTH out of range");
  end
  if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("prbs_checker: LOCK_CNT out of range");
  end
  if (WINDOW < 1 || UNLOCK_ERR < 1) begin : g_bad_window
    $error("prbs_checker: WINDOW and UNLOCK_ERR must be positive");
  end

  prbs_state_e          r_fsm, w_fsm_nxt;
  logic [FILL_W-1:0]    r_fill_cnt, w_fill_nxt;
  logic [MATCH_W-1:0]   r_match_cnt, w_match_nxt;
  logic                 r_locked, r_err, r_err_sat;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_shift, w_sel_pred, w_pred, w_zero;
  logic                 w_mismatch, w_bit_err, w_relock;

  prbs_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_shift    (w_shift),
    .i_sel_pred (w_sel_pred),
    .i_bit      (in_bit),
    .o_pred     (w_pred),
    .o_zero     (w_zero)
  );

  assign w_mismatch = w_pred ^ in_bit;
  assign w_bit_err  = (r_fsm == LOCKED) && en && in_valid && w_mismatch;

`ifdef PRBS_CHK_AUTO_RELOCK_EN
  localparam int WIN_W  = cnt_width(WINDOW);
  localparam int UERR_W = cnt_width(UNLOCK_ERR);

  logic [WIN_W-1:0]  r_win_cnt;
  logic [UERR_W-1:0] r_win_err;
  logic [UERR_W-1:0] w_win_err_inc;

  assign w_win_err_inc = (r_win_err == UERR_W'(UNLOCK_ERR)) ? r_win_err
                                                            : r_win_err + UERR_W'(w_bit_err);
  // The bit that closes a window still counts toward that window's tally.
  assign w_relock = w_bit_err && (w_win_err_inc == UERR_W'(UNLOCK_ERR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (r_fsm != LOCKED || w_fsm_nxt != LOCKED) begin
      r_win_cnt <= '0;
      r_win_err <= '0;
    end else if (in_valid) begin
      if (r_win_cnt == WIN_W'(WINDOW - 1)) begin
        r_win_cnt <= '0;
        r_win_err <= '0;
      end else begin
        r_win_cnt <= r_win_cnt + 1'b1;
        r_win_err <= w_win_err_inc;
      end
    end
  end
`else
  assign w_relock = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= IDLE;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_match_cnt <= w_match_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_fill_nxt  = r_fill_cnt;
    w_match_nxt = r_match_cnt;
    w_shift     = 1'b0;
    w_sel_pred  = 1'b0;
    if (!en) begin
      w_fsm_nxt   = IDLE;
      w_fill_nxt  = '0;
      w_match_nxt = '0;
    end else begin
      case (r_fsm)
        IDLE: begin
          w_fsm_nxt   = FILL;
          w_fill_nxt  = '0;
          w_match_nxt = '0;
        end
        FILL: begin
          if (in_valid) begin
            w_shift = 1'b1;
            if (r_fill_cnt == FILL_W'(WIDTH - 1)) begin
              w_fill_nxt = '0;
              w_fsm_nxt  = VERIFY;
            end else begin
              w_fill_nxt = r_fill_cnt + 1'b1;
            end
          end
        end
        VERIFY: begin
          // Always shift the received bit: after a miss the register still
          // holds the latest WIDTH bits, so no refill is needed.
          if (in_valid) begin
            w_shift = 1'b1;
            if (w_zero || w_mismatch) begin
              w_match_nxt = '0;
            end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
              w_match_nxt = '0;
              w_fsm_nxt   = LOCKED;
            end else begin
              w_match_nxt = r_match_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (in_valid) begin
            w_shift    = 1'b1;
            w_sel_pred = 1'b1;
            if (w_relock) begin
              w_fsm_nxt = FILL;
            end
          end
        end
        default: w_fsm_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_err_sat <= 1'b0;
    end else begin
      r_locked <= (w_fsm_nxt == LOCKED);
      r_err    <= w_bit_err;
      if (clr) begin
        r_err_cnt <= '0;
        r_err_sat <= 1'b0;
      end else if (w_bit_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == {{(ERR_CNT_W-1){1'b1}}, 1'b0}) begin
          r_err_sat <= 1'b1;
        end
      end
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_cnt   = r_err_cnt;
  assign err_sat   = r_err_sat;
  assign dbg_state = r_fsm;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker (PRBS7, LOCK_CNT=16, 4-bit error counter).
module tb_prbs_checker;
  import prbs_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        clr;
  logic        in_valid;
  logic        in_bit;
  logic        locked;
  logic        err;
  logic [3:0]  err_cnt;
  logic        err_sat;
  prbs_state_e dbg_state;

  int          checks;
  int          errors;
  int          locked_seen;
  int          err_seen;
  int          vcnt;
  logic [6:0]  gen;
  logic        e;
  logic        exp_q[$];

  prbs_checker #(
    .WIDTH      (7),
    .TAPS       (7'h60),
    .LOCK_CNT   (16),
    .ERR_CNT_W  (4),
    .WINDOW     (64),
    .UNLOCK_ERR (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_sat   (err_sat),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs read one falling
  // edge later, i.e. after the rising edge that sampled the bit.
  task automatic drive_raw(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(negedge clk);
    if (locked) locked_seen++;
    if (err) err_seen++;
  endtask

  task automatic drive_bit(input logic flip);
    logic nb;
    nb  = ^(gen & 7'h60);
    gen = {gen[5:0], nb};
    drive_raw(1'b1, nb ^ flip);
  endtask

  initial begin
    checks = 0; errors = 0; locked_seen = 0; err_seen = 0; vcnt = 0;
    gen = 7'h7F;
    reset_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_sat", err_sat, 0);
    check("rst_state", dbg_state, IDLE);
    reset_n = 1'b1;
    drive_raw(1'b1, 1'b1);
    check("idle_no_en", dbg_state, IDLE);

    // Lock on a clean continuous stream: 7 fill bits + 16 matches.
    en = 1'b1;
    drive_raw(1'b0, 1'b0);
    check("en_to_fill", dbg_state, FILL);
    for (int i = 1; i <= 22; i++) drive_bit(1'b0);
    check("lock_bit22", locked, 0);
    check("verify_bit22", dbg_state, VERIFY);
    drive_bit(1'b0);
    check("lock_bit23", locked, 1);
    check("state_bit23", dbg_state, LOCKED);
    err_seen = 0;
    for (int i = 24; i <= 1000; i++) drive_bit(1'b0);
    check("clean_err_pulses", err_seen, 0);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_locked", locked, 1);

    // Single flipped bit: one err pulse in the cycle after it.
    for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 20; i++) exp_q.push_back(1'b0);
    err_seen = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drive_bit(e);
      check("err_seq", err, e);
    end
    check("flip_err_pulses", err_seen, 1);
    check("flip_err_cnt", err_cnt, 1);
    check("flip_locked", locked, 1);

    // 19 more isolated errors, 4-bit counter saturates at 15.
    for (int k = 1; k <= 19; k++) begin
      repeat (9) drive_bit(1'b0);
      drive_bit(1'b1);
      check("sat_err_pulse", err, 1);
      if (k == 13) begin
        check("sat_cnt_14", err_cnt, 14);
        check("sat_flag_14", err_sat, 0);
      end
      if (k == 14) begin
        check("sat_cnt_15", err_cnt, 15);
        check("sat_flag_15", err_sat, 1);
      end
    end
    check("sat_cnt_final", err_cnt, 15);
    check("sat_flag_final", err_sat, 1);
    check("sat_locked", locked, 1);

    // clr coincident with an error: counter clears, pulse still emitted.
    clr = 1'b1;
    drive_bit(1'b1);
    clr = 1'b0;
    check("clr_err_pulse", err, 1);
    check("clr_err_cnt", err_cnt, 0);
    check("clr_err_sat", err_sat, 0);
    drive_bit(1'b0);
    check("post_clr_cnt", err_cnt, 0);
    drive_bit(1'b1);
    check("post_clr_err", err_cnt, 1);

    // en drop while locked.
    en = 1'b0;
    drive_bit(1'b1);
    check("en_drop_locked", locked, 0);
    check("en_drop_state", dbg_state, IDLE);
    check("en_drop_err", err, 0);
    check("en_drop_cnt_held", err_cnt, 1);

    // All-zero stream never locks.
    en = 1'b1;
    drive_raw(1'b0, 1'b0);
    locked_seen = 0;
    repeat (200) drive_raw(1'b1, 1'b0);
    check("zero_never_locks", locked_seen, 0);
    check("zero_state", dbg_state, VERIFY);

    // Random 50% valid: lock exactly at valid bit 23.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    drive_raw(1'b0, 1'b0);
    check("rand_fill", dbg_state, FILL);
    gen = 7'h7F;
    vcnt = 0;
    for (int c = 0; c < 2000 && vcnt < 23; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        drive_bit(1'b0);
        vcnt++;
      end else begin
        drive_raw(1'b0, 1'($urandom_range(0, 1)));
      end
      check("rand_lock", locked, (vcnt == 23) ? 1 : 0);
    end
    check("rand_valid_count", vcnt, 23);

`ifdef PRBS_CHK_AUTO_RELOCK_EN
    // 8 errors inside one window force relock, then 23 clean bits relock.
    for (int k = 1; k <= 8; k++) begin
      drive_bit(1'b1);
      check("relock_locked", locked, (k == 8) ? 0 : 1);
      if (k < 8) drive_bit(1'b0);
    end
    check("relock_state", dbg_state, FILL);
    check("relock_cnt_kept", err_cnt, 8);
    for (int i = 1; i <= 22; i++) drive_bit(1'b0);
    check("relock_bit22", locked, 0);
    drive_bit(1'b0);
    check("relock_bit23", locked, 1);
`endif

    // Asynchronous reset while locked with a live error pulse.
    drive_bit(1'b1);
    check("pre_rst_err", err, 1);
`ifdef PRBS_CHK_AUTO_RELOCK_EN
    check("pre_rst_cnt", err_cnt, 9);
`else
    check("pre_rst_cnt", err_cnt, 1);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_err", err, 0);
    check("async_err_cnt", err_cnt, 0);
    check("async_err_sat", err_sat, 0);
    check("async_state", dbg_state, IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
